// File: rtl/wb_line_fetch_pkg.sv
// Shared types for the line fetcher: FSM state encoding and Wishbone response
// decoding with priority err > rty > ack.
package wb_line_fetch_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StHold,
    StDone
  } fetch_state_e;

  // Enumerator order doubles as response priority, highest last.
  typedef enum logic [1:0] {
    RespNone,
    RespAck,
    RespRty,
    RespErr
  } wb_resp_e;

  function automatic wb_resp_e wb_resp_decode(input logic ack, input logic err, input logic rty);
    wb_resp_e resp;
    resp = RespNone;
    if (err) begin
      resp = RespErr;
    end else if (rty) begin
      resp = RespRty;
    end else if (ack) begin
      resp = RespAck;
    end
    return resp;
  endfunction

endpackage

// File: rtl/wb_fetch_fifo.sv
// Synchronous FIFO with occupancy output; head word is read straight from the
// storage registers so rd_data is valid whenever rd_valid is high.
module wb_fetch_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_AW    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic [FIFO_AW:0]      level
);

  localparam int unsigned Depth = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] FullLevel = (FIFO_AW + 1)'(Depth);

  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic [FIFO_AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]      level_q;
  logic                  do_push, do_pop;

  assign do_pop  = pop && (level_q != '0);
  // A pop frees the slot in the same cycle, so push at full is fine alongside it.
  assign do_push = push && ((level_q != FullLevel) || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + (FIFO_AW + 1)'(1);
        2'b01:   level_q <= level_q - (FIFO_AW + 1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  assign rd_data  = mem_q[rd_ptr_q];
  assign rd_valid = (level_q != '0);
  assign level    = level_q;

endmodule

// File: rtl/wb_line_fetch.sv
// Wishbone classic read master that streams one line of consecutive words into
// a local FIFO, releasing cyc between bursts and whenever the FIFO is full.
module wb_line_fetch
  import wb_line_fetch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned SELECT_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned LEN_WIDTH    = 10,
  parameter int unsigned FIFO_AW      = 4,
  parameter int unsigned MAX_BURST    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   base_adr,
  input  logic [LEN_WIDTH-1:0]    word_cnt,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [FIFO_AW:0]        fifo_level,
  output logic [ADDR_WIDTH-1:0]   wbm_adr_o,
  input  logic [DATA_WIDTH-1:0]   wbm_dat_i,
  output logic [DATA_WIDTH-1:0]   wbm_dat_o,
  output logic                    wbm_we_o,
  output logic [SELECT_WIDTH-1:0] wbm_sel_o,
  output logic                    wbm_stb_o,
  input  logic                    wbm_ack_i,
  input  logic                    wbm_err_i,
  input  logic                    wbm_rty_i,
  output logic                    wbm_cyc_o,
  input  logic                    arb_sel
);

  localparam int unsigned BurstW = $clog2(MAX_BURST + 1);
  localparam logic [FIFO_AW:0] FullLevel = (FIFO_AW + 1)'(2 ** FIFO_AW);

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
  logic [BurstW-1:0]     burst_q, burst_d;
  logic                  err_q, err_d;
  logic                  fifo_free, req_active;
  wb_resp_e              resp;

  // The free slot is reserved for the one word in flight; only our own push
  // can fill it, so stb never drops while a read is outstanding.
  assign fifo_free  = (fifo_level != FullLevel);
  assign req_active = (state_q == StReq) && fifo_free;

  assign resp = wb_resp_decode(wbm_ack_i && arb_sel && req_active,
                               wbm_err_i && arb_sel && req_active,
                               wbm_rty_i && arb_sel && req_active);

  always_comb begin
    state_d     = state_q;
    adr_d       = adr_q;
    remaining_d = remaining_q;
    burst_d     = burst_q;
    err_d       = err_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          err_d = 1'b0;
          if (word_cnt != '0) begin
            adr_d       = base_adr;
            remaining_d = word_cnt;
            burst_d     = '0;
            state_d     = StReq;
          end else begin
            state_d = StDone;
          end
        end
      end
      StReq: begin
        if (!fifo_free) begin
          state_d = StHold;
        end else begin
          unique case (resp)
            RespErr: begin
              err_d   = 1'b1;
              state_d = StDone;
            end
            RespRty: state_d = StHold;
            RespAck: begin
              adr_d       = adr_q + ADDR_WIDTH'(SELECT_WIDTH);
              remaining_d = remaining_q - LEN_WIDTH'(1);
              burst_d     = burst_q + BurstW'(1);
              if (remaining_q == LEN_WIDTH'(1)) begin
                state_d = StDone;
              end else if (burst_q == BurstW'(MAX_BURST - 1)) begin
                state_d = StHold;
              end
            end
            RespNone: state_d = StReq;
          endcase
        end
      end
      StHold: begin
        burst_d = '0;
        if (fifo_free) begin
          state_d = StReq;
        end
      end
      StDone: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      adr_q       <= '0;
      remaining_q <= '0;
      burst_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      adr_q       <= adr_d;
      remaining_q <= remaining_d;
      burst_q     <= burst_d;
      err_q       <= err_d;
    end
  end

  wb_fetch_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .FIFO_AW   (FIFO_AW)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (resp == RespAck),
    .push_data(wbm_dat_i),
    .pop      (rd_ready),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .level    (fifo_level)
  );

  assign busy      = (state_q == StReq) || (state_q == StHold);
  assign done      = (state_q == StDone);
  assign err       = err_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = '0;
  assign wbm_we_o  = 1'b0;
  assign wbm_sel_o = '1;
  assign wbm_stb_o = req_active;
  assign wbm_cyc_o = req_active;

endmodule

// File: tb/tb_wb_line_fetch.sv
// Directed bench for wb_line_fetch: a table of line fetches against a
// combinational slave model, plus hand-written full-FIFO and reset sequences.
module tb_wb_line_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_adr = '0;
  logic [9:0]  word_cnt = '0;
  logic        busy, done, err;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic [4:0]  fifo_level;
  logic [31:0] wbm_adr_o, wbm_dat_i, wbm_dat_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_stb_o, wbm_ack_i, wbm_err_i, wbm_rty_i, wbm_cyc_o;
  logic        arb_sel = 1'b1;

  wb_line_fetch dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_adr  (base_adr),
    .word_cnt  (word_cnt),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .fifo_level(fifo_level),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_i (wbm_dat_i),
    .wbm_dat_o (wbm_dat_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_sel_o (wbm_sel_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_ack_i (wbm_ack_i),
    .wbm_err_i (wbm_err_i),
    .wbm_rty_i (wbm_rty_i),
    .wbm_cyc_o (wbm_cyc_o),
    .arb_sel   (arb_sel)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] adr);
    return adr ^ 32'hC0DE_0000;
  endfunction

  // Slave: acks every strobe; err/rty are layered on top so priority matters.
  logic        err_en = 1'b0, rty_en = 1'b0;
  logic [31:0] err_adr = '0, rty_adr = '0;
  int          rty_snap = 0;
  int          rty_cnt = 0;

  always_comb begin
    wbm_dat_i = mem_word(wbm_adr_o);
    wbm_ack_i = wbm_cyc_o && wbm_stb_o;
    wbm_err_i = wbm_cyc_o && wbm_stb_o && err_en && (wbm_adr_o == err_adr);
    wbm_rty_i = wbm_cyc_o && wbm_stb_o && rty_en && (wbm_adr_o == rty_adr) &&
                (rty_cnt == rty_snap);
  end

  int          cycle = 0;
  int          gaps = 0, stray = 0, done_cnt = 0, done_cyc = 0, last_resp_cyc = 0;
  logic        prev_stb = 1'b0;
  logic [31:0] ack_adr_q[$];
  logic [31:0] popped_q[$];
  int          rise_cyc_q[$];

  always @(posedge clk) begin
    cycle    <= cycle + 1;
    prev_stb <= wbm_stb_o;
    if (wbm_stb_o && !prev_stb) rise_cyc_q.push_back(cycle);
    if (busy && !wbm_cyc_o) gaps <= gaps + 1;
    if (wbm_stb_o && !busy) stray <= stray + 1;
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cycle;
    end
    if (rd_valid && rd_ready) popped_q.push_back(rd_data);
    if (wbm_cyc_o && wbm_stb_o && arb_sel) begin
      if (wbm_err_i) begin
        last_resp_cyc <= cycle;
      end else if (wbm_rty_i) begin
        rty_cnt <= rty_cnt + 1;
      end else if (wbm_ack_i) begin
        ack_adr_q.push_back(wbm_adr_o);
        last_resp_cyc <= cycle;
      end
    end
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rd;
    logic [31:0] base;
    logic [9:0]  cnt;
    int          err_idx;
    int          rty_idx;
    int          acks;
    logic        err;
    int          level;
    int          gaps;
    int          rises;
  } vec_t;

  vec_t vecs[7];

  task automatic wait_done(input int d0);
    for (int k = 0; k < 300 && done_cnt == d0; k++) @(negedge clk);
    chk("done_seen", 64'(done_cnt - d0), 64'd1);
  endtask

  initial begin
    vec_t v;
    int   a0, p0, d0, g0, r0, s0, st, exp_done;
    logic [31:0] ea;

    //          rd    base           cnt  err rty acks err lvl gaps rises
    vecs[0] = '{1'b1, 32'h0000_0100,  4,  -1, -1,  4, 1'b0, 0, 0, 1};
    vecs[1] = '{1'b1, 32'h0000_1000, 16,  -1, -1, 16, 1'b0, 0, 1, 2};
    vecs[2] = '{1'b0, 32'h0000_0300,  5,   2, -1,  2, 1'b1, 2, 0, 1};
    vecs[3] = '{1'b1, 32'h0000_0200,  4,  -1,  1,  4, 1'b0, 0, 1, 2};
    vecs[4] = '{1'b1, 32'h0000_0400,  0,  -1, -1,  0, 1'b0, 0, 0, 0};
    vecs[5] = '{1'b1, 32'hFFFF_FFF8,  3,  -1, -1,  3, 1'b0, 0, 0, 1};
    vecs[6] = '{1'b0, 32'h0000_0500, 10,  -1, -1, 10, 1'b0, 10, 1, 2};

    repeat (3) @(negedge clk);
    chk("rst_cyc", 64'(wbm_cyc_o), 64'd0);
    chk("rst_stb", 64'(wbm_stb_o), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_adr", 64'(wbm_adr_o), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("sel_ones", 64'(wbm_sel_o), 64'hF);
    chk("we_zero", 64'(wbm_we_o), 64'd0);
    chk("dat_o_zero", 64'(wbm_dat_o), 64'd0);

    for (int i = 0; i < 7; i++) begin
      v = vecs[i];
      rd_ready = v.rd;
      err_en   = (v.err_idx >= 0);
      err_adr  = v.base + 32'(4 * v.err_idx);
      rty_en   = (v.rty_idx >= 0);
      rty_adr  = v.base + 32'(4 * v.rty_idx);
      rty_snap = rty_cnt;
      a0 = ack_adr_q.size(); p0 = popped_q.size(); r0 = rise_cyc_q.size();
      d0 = done_cnt; g0 = gaps; s0 = stray;
      start = 1'b1; base_adr = v.base; word_cnt = v.cnt; st = cycle;
      @(negedge clk);
      start = 1'b0;
      chk($sformatf("v%0d_err_clear", i), 64'(err), 64'd0);
      chk($sformatf("v%0d_busy", i), 64'(busy), 64'(v.cnt != 0));
      wait_done(d0);
      exp_done = (v.cnt == 0) ? st + 1 : last_resp_cyc + 1;
      chk($sformatf("v%0d_done_cycle", i), 64'(done_cyc), 64'(exp_done));
      repeat (2) @(negedge clk);
      chk($sformatf("v%0d_done_once", i), 64'(done_cnt - d0), 64'd1);
      chk($sformatf("v%0d_err", i), 64'(err), 64'(v.err));
      chk($sformatf("v%0d_busy_end", i), 64'(busy), 64'd0);
      chk($sformatf("v%0d_acks", i), 64'(ack_adr_q.size() - a0), 64'(v.acks));
      for (int j = 0; j < v.acks && a0 + j < ack_adr_q.size(); j++) begin
        ea = v.base + 32'(4 * j);
        chk($sformatf("v%0d_adr%0d", i, j), 64'(ack_adr_q[a0 + j]), 64'(ea));
      end
      if (v.cnt != 0 && rise_cyc_q.size() > r0)
        chk($sformatf("v%0d_first_stb", i), 64'(rise_cyc_q[r0]), 64'(st + 1));
      chk($sformatf("v%0d_gaps", i), 64'(gaps - g0), 64'(v.gaps));
      chk($sformatf("v%0d_rises", i), 64'(rise_cyc_q.size() - r0), 64'(v.rises));
      chk($sformatf("v%0d_stray", i), 64'(stray - s0), 64'd0);
      chk($sformatf("v%0d_level", i), 64'(fifo_level), 64'(v.level));
      rd_ready = 1'b1;
      repeat (20) @(negedge clk);
      chk($sformatf("v%0d_popped", i), 64'(popped_q.size() - p0), 64'(v.acks));
      for (int j = 0; j < v.acks && p0 + j < popped_q.size(); j++) begin
        ea = mem_word(v.base + 32'(4 * j));
        chk($sformatf("v%0d_data%0d", i, j), 64'(popped_q[p0 + j]), 64'(ea));
      end
    end
    err_en = 1'b0;
    rty_en = 1'b0;

    // FIFO fills: 16 acks then cyc stays low; one pop lets exactly one read out.
    rd_ready = 1'b0;
    a0 = ack_adr_q.size(); p0 = popped_q.size(); d0 = done_cnt;
    start = 1'b1; base_adr = 32'h0000_2000; word_cnt = 10'd20;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    chk("full_acks", 64'(ack_adr_q.size() - a0), 64'd16);
    chk("full_cyc", 64'(wbm_cyc_o), 64'd0);
    chk("full_level", 64'(fifo_level), 64'd16);
    chk("full_busy", 64'(busy), 64'd1);
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
    repeat (10) @(negedge clk);
    chk("pop1_acks", 64'(ack_adr_q.size() - a0), 64'd17);
    chk("pop1_level", 64'(fifo_level), 64'd16);
    chk("pop1_cyc", 64'(wbm_cyc_o), 64'd0);
    rd_ready = 1'b1;
    wait_done(d0);
    repeat (20) @(negedge clk);
    chk("full_total_acks", 64'(ack_adr_q.size() - a0), 64'd20);
    chk("full_popped", 64'(popped_q.size() - p0), 64'd20);
    for (int j = 0; j < 20 && p0 + j < popped_q.size(); j++) begin
      ea = mem_word(32'h0000_2000 + 32'(4 * j));
      chk($sformatf("full_data%0d", j), 64'(popped_q[p0 + j]), 64'(ea));
    end

    // No grant: strobe held with stable address, acks ignored; then reset mid-burst.
    rd_ready = 1'b0;
    arb_sel  = 1'b0;
    a0 = ack_adr_q.size(); d0 = done_cnt;
    start = 1'b1; base_adr = 32'h0000_0600; word_cnt = 10'd12;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("nogrant_stb", 64'(wbm_stb_o), 64'd1);
    chk("nogrant_adr", 64'(wbm_adr_o), 64'h600);
    chk("nogrant_acks", 64'(ack_adr_q.size() - a0), 64'd0);
    arb_sel = 1'b1;
    repeat (3) @(negedge clk);
    chk("grant_level", 64'(fifo_level), 64'd3);
    chk("grant_adr", 64'(wbm_adr_o), 64'h60C);
    chk("pre_rst_cyc", 64'(wbm_cyc_o), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cyc", 64'(wbm_cyc_o), 64'd0);
    chk("mid_rst_stb", 64'(wbm_stb_o), 64'd0);
    chk("mid_rst_level", 64'(fifo_level), 64'd0);
    chk("mid_rst_valid", 64'(rd_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_adr", 64'(wbm_adr_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("mid_rst_no_done", 64'(done_cnt - d0), 64'd0);
    chk("mid_rst_idle_cyc", 64'(wbm_cyc_o), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
